// File: rtl/npu_pkg.sv
// Shared definitions for the NPU memory loader.
//   loader_state_t : FSM state encoding (IDLE, WRITE, READ, DONE)
//   NPU_AXI_WIDTH  : default memory data width
//   NPU_ADDR_W     : default NPU buffer word-index width
//   NPU_LEN_W      : default burst length field width
//   NPU_WEN_FULL   : byte-enable for a full-word write
package npu_pkg;

  localparam int NPU_AXI_WIDTH = 32;
  localparam int NPU_ADDR_W    = 6;
  localparam int NPU_LEN_W     = 7;

  localparam logic [3:0] NPU_WEN_FULL = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/npu_skid_buf.sv
// Two-entry FIFO that buffers read data returned by the NPU buffer so the
// read stream can be backpressured without losing words already in flight.
// Ports:
//   clk, rst            : clock, synchronous active-high flush
//   i_valid/o_ready/i_data  : push side
//   o_valid/i_ready/o_data  : pop side (o_data is 0 while empty)
//   o_count             : current occupancy (0..2)
module npu_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage is data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/npu_mem_loader.sv
// Burst loader between a command/stream interface and the SRAM-like port of
// an NPU buffer. Write bursts stream wr_data straight onto the memory port;
// read bursts issue requests and collect returned data in a 2-entry skid
// buffer that feeds the rd stream.
// Build option: NPU_LOADER_READBACK_EN builds the read path and skid buffer.
// Without it, read commands complete immediately with no memory access.
// Ports:
//   clk, rst_n                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_rd, cmd_addr, cmd_len      : direction, start word, word count
//   wr_valid/wr_ready/wr_data      : write-data stream (in)
//   rd_valid/rd_ready/rd_data      : read-data stream (out)
//   busy, done                     : status, one-cycle completion pulse
//   req_o/wen_o/addr_o/wdata_o     : memory request port
//   rdata_i                        : memory read data, one cycle after request
module npu_mem_loader
  import npu_pkg::*;
#(
  parameter int AXI_WIDTH = NPU_AXI_WIDTH,
  parameter int ADDR_W    = NPU_ADDR_W,
  parameter int LEN_W     = NPU_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AXI_WIDTH-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [AXI_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 req_o,
  output logic [3:0]           wen_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [AXI_WIDTH-1:0] wdata_o,
  input  logic [AXI_WIDTH-1:0] rdata_i
);

  loader_state_t        r_state;
  loader_state_t        w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_addr_hold;
  logic [AXI_WIDTH-1:0] r_wdata_hold;
  logic [LEN_W-1:0]     r_issue_left;
  logic [LEN_W-1:0]     r_accept_left;
  logic                 w_cmd_fire;
  logic                 w_wr_issue;
  logic                 w_rd_issue;
  logic                 w_rd_accept;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_wr_issue = (r_state == S_WRITE) && wr_valid;

`ifdef NPU_LOADER_READBACK_EN
  logic                 r_rd_vld_p1;
  logic                 w_in_read;
  logic                 w_skid_in_ready;
  logic                 w_skid_out_valid;
  logic [AXI_WIDTH-1:0] w_skid_out_data;
  logic [1:0]           w_skid_count;
  logic [2:0]           w_occ;

  assign w_in_read   = (r_state == S_READ);
  assign w_rd_accept = w_in_read && w_skid_out_valid && rd_ready;
  // Credit for a word leaving the skid buffer this cycle is returned
  // immediately, which keeps the read stream at one word per cycle while
  // never letting in-flight plus buffered words exceed two.
  assign w_occ       = 3'(r_rd_vld_p1) + 3'(w_skid_count) - 3'(w_rd_accept);
  assign w_rd_issue  = w_in_read && (r_issue_left != '0) && (w_occ < 3'd2)
                       && w_skid_in_ready;
  assign rd_valid    = w_skid_out_valid;
  assign rd_data     = w_skid_out_data;

  // Stage p1: a request issued last cycle has its data on rdata_i now.
  // Clearing this on reset drops any read that returns after the abort.
  always_ff @(posedge clk) begin
    if (rst_n) r_rd_vld_p1 <= 1'b0;
    else       r_rd_vld_p1 <= w_rd_issue;
  end

  npu_skid_buf #(
    .DATA_W(AXI_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst_n),
    .i_valid (r_rd_vld_p1),
    .o_ready (w_skid_in_ready),
    .i_data  (rdata_i),
    .o_valid (w_skid_out_valid),
    .i_ready (w_in_read && rd_ready),
    .o_data  (w_skid_out_data),
    .o_count (w_skid_count)
  );
`else
  logic w_unused_rd;

  assign w_rd_issue  = 1'b0;
  assign w_rd_accept = 1'b0;
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
  assign w_unused_rd = ^{rd_ready, rdata_i};
`endif

  // Memory port: address/data are live only while issuing, otherwise the
  // last issued values are held.
  assign req_o   = w_wr_issue || w_rd_issue;
  assign wen_o   = w_wr_issue ? NPU_WEN_FULL : 4'h0;
  assign addr_o  = req_o ? r_addr : r_addr_hold;
  assign wdata_o = w_wr_issue ? wr_data : r_wdata_hold;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Held low while reset is asserted so no command is taken then.
        cmd_ready = !rst_n;
        if (w_cmd_fire) begin
          if (cmd_len == '0) begin
            w_state_nxt = S_DONE;
          end else if (cmd_rd) begin
`ifdef NPU_LOADER_READBACK_EN
            w_state_nxt = S_READ;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (w_wr_issue && (r_issue_left == LEN_W'(1))) w_state_nxt = S_DONE;
      end
      S_READ: begin
        busy = 1'b1;
        if (w_rd_accept && (r_accept_left == LEN_W'(1))) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_addr        <= '0;
      r_addr_hold   <= '0;
      r_wdata_hold  <= '0;
      r_issue_left  <= '0;
      r_accept_left <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_addr        <= cmd_addr;
        r_issue_left  <= cmd_len;
        r_accept_left <= cmd_len;
      end
      if (req_o) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_addr_hold  <= r_addr;
        r_issue_left <= r_issue_left - LEN_W'(1);
      end
      if (w_wr_issue)  r_wdata_hold  <= wr_data;
      if (w_rd_accept) r_accept_left <= r_accept_left - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_npu_mem_loader.sv
// Bench for npu_mem_loader: table of bursts plus hand-written reset and
// idle-activity sequences. Expected memory writes and read words are queued
// when stimulus is driven and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_npu_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [6:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        req_o;
  logic [3:0]  wen_o;
  logic [5:0]  addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = '0;

  always #5 clk = ~clk;

  npu_mem_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .req_o(req_o), .wen_o(wen_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i)
  );

  typedef struct {
    logic        rd;
    logic [5:0]  addr;
    logic [6:0]  len;
    logic [31:0] dbase;
    logic        stall;
    int          exp_reqs;
    logic [5:0]  exp_hold;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     wq[$];
  logic [31:0] rq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_done   = 0;
  int n_rd_iss = 0;
  int n_rd_acc = 0;
  bit rd_mode  = 1'b0;

  function automatic logic [31:0] rd_word(input logic [5:0] a);
    return 32'h5A00_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: read data appears exactly one cycle after a read request,
  // and is junk otherwise.
  always @(posedge clk) begin
    rdata_i <= (req_o && wen_o == 4'h0) ? rd_word(addr_o) : $urandom;
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    wr_exp_t e;
    if (done) n_done++;
    if (req_o) begin
      n_req++;
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_addr", 64'(addr_o), 64'(e.addr));
        check("wr_wen", 64'(wen_o), 64'h0F);
        check("wr_data", 64'(wdata_o), 64'(e.data));
      end else if (rd_mode) begin
        n_rd_iss++;
        check("rd_wen", 64'(wen_o), 64'h0);
      end else begin
        check("unexpected_req", 64'(req_o), 64'h0);
      end
    end
    if (rd_valid && rd_ready) begin
      n_rd_acc++;
      if (rq.size() != 0) check("rd_data", 64'(rd_data), 64'(rq.pop_front()));
      else                check("unexpected_rd", 64'(rd_valid), 64'h0);
    end
    if (rd_mode) check("outstanding_le2", 64'((n_rd_iss - n_rd_acc) <= 2), 64'h1);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
    check({tag, "_busy"},      64'(busy),      64'h0);
    check({tag, "_done"},      64'(done),      64'h0);
    check({tag, "_wr_ready"},  64'(wr_ready),  64'h0);
    check({tag, "_rd_valid"},  64'(rd_valid),  64'h0);
    check({tag, "_req_o"},     64'(req_o),     64'h0);
    check({tag, "_wen_o"},     64'(wen_o),     64'h0);
    check({tag, "_addr_o"},    64'(addr_o),    64'h0);
    check({tag, "_wdata_o"},   64'(wdata_o),   64'h0);
    check({tag, "_rd_data"},   64'(rd_data),   64'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int req0;
    int done0;
    int cyc;
    logic [5:0] a;
    req0  = n_req;
    done0 = n_done;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rd = v.rd; cmd_addr = v.addr; cmd_len = v.len;
    @(negedge clk);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
    if (!v.rd && v.len != 0) begin
      for (int k = 0; k < int'(v.len); k++) begin
        if (v.stall && (k % 2 == 1)) begin
          @(posedge clk); #1;
          cmd_valid = 1'b0; wr_valid = 1'b0;
          @(negedge clk);
          check({tag, "_stall_req"}, 64'(req_o), 64'h0);
          check({tag, "_stall_busy"}, 64'(busy), 64'h1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = v.dbase + 32'(k);
        a = v.addr + 6'(k);
        wq.push_back('{addr: a, data: wr_data});
        @(negedge clk);
        check({tag, "_wr_req"},   64'(req_o),    64'h1);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'h1);
        check({tag, "_busy"},     64'(busy),     64'h1);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(negedge clk);
      check({tag, "_done"},     64'(done),     64'h1);
      check({tag, "_done_busy"}, 64'(busy),    64'h0);
      check({tag, "_done_wrdy"}, 64'(wr_ready), 64'h0);
    end
`ifdef NPU_LOADER_READBACK_EN
    else if (v.rd && v.len != 0) begin
      rd_mode = 1'b1; n_rd_iss = 0; n_rd_acc = 0;
      for (int k = 0; k < int'(v.len); k++) rq.push_back(rd_word(v.addr + 6'(k)));
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cmd_valid = 1'b0; rd_ready = (cyc >= 3);
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 60);
      check({tag, "_done"},    64'(done),      64'h1);
      check({tag, "_rq_left"}, 64'(rq.size()), 64'h0);
      #1;
      check({tag, "_rd_words"}, 64'(n_rd_acc), 64'(v.len));
    end
`endif
    else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, "_done"},     64'(done),     64'h1);
      check({tag, "_req_o"},    64'(req_o),    64'h0);
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'h0);
      check({tag, "_busy"},     64'(busy),     64'h0);
    end
    @(posedge clk); #1;
    rd_ready = 1'b0; rd_mode = 1'b0;
    @(negedge clk); #1;
    check({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'h1);
    check({tag, "_done_after"},      64'(done),      64'h0);
    check({tag, "_req_count"},  64'(n_req - req0),   64'(v.exp_reqs));
    check({tag, "_done_count"}, 64'(n_done - done0), 64'h1);
    check({tag, "_addr_hold"},  64'(addr_o),         64'(v.exp_hold));
    check({tag, "_wen_idle"},   64'(wen_o),          64'h0);
    check({tag, "_wq_left"},    64'(wq.size()),      64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    vec_t vpost;
    int done0;
    int cyc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cmd_ready_in_reset", 64'(cmd_ready), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("por");

    vt[0] = '{rd: 1'b0, addr: 6'd10, len: 7'd3, dbase: 32'hA1, stall: 1'b0, exp_reqs: 3, exp_hold: 6'd12};
    vt[1] = '{rd: 1'b0, addr: 6'd62, len: 7'd3, dbase: 32'hB1, stall: 1'b0, exp_reqs: 3, exp_hold: 6'd0};
    vt[2] = '{rd: 1'b0, addr: 6'd33, len: 7'd0, dbase: 32'h0,  stall: 1'b0, exp_reqs: 0, exp_hold: 6'd0};
    vt[3] = '{rd: 1'b0, addr: 6'd5,  len: 7'd4, dbase: 32'hC0, stall: 1'b1, exp_reqs: 4, exp_hold: 6'd8};
`ifdef NPU_LOADER_READBACK_EN
    vt[4] = '{rd: 1'b1, addr: 6'd20, len: 7'd4, dbase: 32'h0,  stall: 1'b0, exp_reqs: 4, exp_hold: 6'd23};
`else
    vt[4] = '{rd: 1'b1, addr: 6'd20, len: 7'd5, dbase: 32'h0,  stall: 1'b0, exp_reqs: 0, exp_hold: 6'd8};
`endif

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write burst: aborted, no done pulse.
    done0 = n_done;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 6'd40; cmd_len = 7'd5;
    @(negedge clk);
    check("midwr_cmd_ready", 64'(cmd_ready), 64'h1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hF0 + 32'(k);
      wq.push_back('{addr: 6'(40 + k), data: wr_data});
      @(negedge clk);
      check("midwr_req", 64'(req_o), 64'h1);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("midwr_cmd_ready_rst", 64'(cmd_ready), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midwr");
    repeat (3) begin
      @(negedge clk);
      check("midwr_no_done", 64'(done), 64'h0);
    end
    #1;
    check("midwr_done_count", 64'(n_done - done0), 64'h0);

`ifdef NPU_LOADER_READBACK_EN
    // Reset in the middle of a read burst after two words are accepted.
    done0 = n_done;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 6'd50; cmd_len = 7'd5;
    rd_mode = 1'b1; n_rd_iss = 0; n_rd_acc = 0;
    for (int k = 0; k < 5; k++) rq.push_back(rd_word(6'(50 + k)));
    @(negedge clk);
    check("midrd_cmd_ready", 64'(cmd_ready), 64'h1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; rd_ready = 1'b1;
      @(negedge clk); #1;
      cyc++;
    end while (n_rd_acc < 2 && cyc < 30);
    check("midrd_two_words", 64'(n_rd_acc), 64'h2);
    @(posedge clk); #1;
    rst_n = 1'b1; rd_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; rd_mode = 1'b0; rq.delete();
    @(negedge clk);
    check_reset_vals("midrd");
    repeat (3) begin
      @(negedge clk);
      check("midrd_no_rd_valid", 64'(rd_valid), 64'h0);
      check("midrd_no_done", 64'(done), 64'h0);
    end
    #1;
    check("midrd_done_count", 64'(n_done - done0), 64'h0);
`endif

    // New command after the aborted burst is accepted normally.
    vpost = '{rd: 1'b0, addr: 6'd3, len: 7'd2, dbase: 32'hE0, stall: 1'b0, exp_reqs: 2, exp_hold: 6'd4};
    run_vec(vpost, "post");

    // Stream activity while idle is ignored; held write data stays put.
    @(posedge clk); #1;
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_req_o",    64'(req_o),    64'h0);
    check("idle_wr_ready", 64'(wr_ready), 64'h0);
    check("idle_rd_valid", 64'(rd_valid), 64'h0);
    check("idle_busy",     64'(busy),     64'h0);
    check("idle_wdata",    64'(wdata_o),  64'hE1);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_mem_loader.md
NPU_MEM_LOADER -- requirements
Module: npu_mem_loader

Interface
REQ-001 Param AXI_WIDTH, 32, memory data width.
REQ-002 Param ADDR_W, 6, word-index width of the NPU buffer port.
REQ-003 Param LEN_W, 7, burst length field width in words.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-high (1 = reset).
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_rd  in  1  burst direction: 0 = write burst, 1 = read burst.
REQ-008 cmd_addr  in  ADDR_W  starting word index.
REQ-009 cmd_len  in  LEN_W  word count; 0 is legal.
REQ-010 wr_valid/wr_ready/wr_data  in/out/in  1/1/AXI_WIDTH  write-data stream.
REQ-011 rd_valid/rd_ready/rd_data  out/in/out  1/1/AXI_WIDTH  read-data stream.
REQ-012 busy  out  1  high while a command is in progress; done  out  1  one-cycle completion pulse.
REQ-013 req_o/wen_o/addr_o/wdata_o  out  1/4/ADDR_W/AXI_WIDTH  SRAM-like master port.
REQ-014 rdata_i  in  AXI_WIDTH  read data, valid exactly one cycle after the read request.

Function
REQ-015 FSM states are IDLE, WRITE, READ and DONE.
REQ-016 cmd_ready is high only in IDLE; command capture occurs on cmd_valid&&cmd_ready.
REQ-017 A captured command with cmd_len=0 transitions to DONE without any req_o cycle.
REQ-018 In WRITE, wr_ready=1; each wr_valid&&wr_ready cycle drives req_o=1, wen_o=4'hF, addr_o=current address and wdata_o=wr_data in the same cycle.
REQ-019 In READ, a read is issued (req_o=1, wen_o=4'h0) only when in-flight reads plus skid occupancy is less than 2.
REQ-020 Returned rdata_i is pushed into the skid buffer one cycle after issue; rd_valid=skid non-empty; rd_data=skid head.
REQ-021 The address increments by 1 per issued access and wraps modulo 2^ADDR_W, e.g. 63 -> 0.
REQ-022 When idle, req_o=0 and wen_o=0; addr_o and wdata_o hold their last values.
REQ-023 WRITE -> DONE occurs in the cycle after the last write is issued; READ -> DONE occurs when the last read word is accepted on rd.
REQ-024 DONE lasts one cycle: done=1, busy=0, and the next state is IDLE.
REQ-025 busy=1 in WRITE and READ; busy=0 in IDLE and DONE.
REQ-026 Sustained throughput is one word per cycle in both directions when the streams do not stall.
REQ-027 wr_valid or rd_ready activity outside the matching state is ignored, and the opposite stream's ready/valid stays 0.

Reset
REQ-028 While rst_n=1 at a clock edge: state=IDLE, counters=0, skid buffer flushed, and in-flight read tracking cleared.
REQ-029 Reset values: cmd_ready=0 during reset and 1 in the first cycle after reset; busy=0, done=0, rd_valid=0, wr_ready=0, req_o=0, wen_o=0, addr_o=0, wdata_o=0, rd_data=0.
REQ-030 Reset mid-burst aborts the burst without a done pulse; a read returning after reset is discarded.

Configuration
REQ-031 Macro NPU_LOADER_READBACK_EN: when defined, the READ path and skid buffer are built.
REQ-032 Without NPU_LOADER_READBACK_EN, a command with cmd_rd=1 is accepted, performs no memory access and produces done one cycle later; rd_valid is tied to 0 and rd_data is tied to 0.

Structure
REQ-033 Package npu_pkg holds the loader_state_t enum, the default AXI_WIDTH/ADDR_W/LEN_W constants and the 4'hF full-word byte-enable constant.
REQ-034 Sub-module npu_skid_buf is a 2-entry FIFO with valid/ready ports, instantiated only under NPU_LOADER_READBACK_EN.

Verification
REQ-035 Write burst: cmd addr=10, len=3, wr_data 0xA1,0xA2,0xA3 streamed back-to-back -> writes at 10,11,12 on consecutive cycles, wen_o=4'hF, done pulses one cycle later.
REQ-036 Wrap: write burst addr=62, len=3 -> addr_o sequence 62,63,0.
REQ-037 Read burst with backpressure: addr=20, len=4, rd_ready low for 3 cycles -> at most 2 reads outstanding, words returned in order 20..23 with none lost or duplicated.
REQ-038 Zero length: cmd len=0 -> no req_o cycle, done pulses one cycle after the command is accepted, cmd_ready is 1 the next cycle.
REQ-039 Reset mid-read after 2 of 5 words -> all outputs return to reset values, no done pulse, and a new command is accepted normally afterwards.
REQ-040 Macro off: cmd_rd=1, len=5 -> req_o stays 0, rd_valid stays 0, done pulses once.
